// File: rtl/niu32_pkg.sv
// Shared constants and address decode for the Niu32 memory-mapped I/O page.
package niu32_pkg;

  localparam int WORD_SIZE = 32;

  // Upper address half that selects the I/O page.
  localparam logic [15:0] IO_PAGE = 16'hFFFF;

  localparam logic [WORD_SIZE-1:0] ADDR_HEX     = 32'hFFFF_0000;
  localparam logic [WORD_SIZE-1:0] ADDR_LEDR    = 32'hFFFF_0020;
  localparam logic [WORD_SIZE-1:0] ADDR_LEDG    = 32'hFFFF_0040;
  localparam logic [WORD_SIZE-1:0] ADDR_KEY     = 32'hFFFF_0100;
  localparam logic [WORD_SIZE-1:0] ADDR_KEYSTAT = 32'hFFFF_0104;
  localparam logic [WORD_SIZE-1:0] ADDR_SWITCH  = 32'hFFFF_0120;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_HEX,
    SEL_LEDR,
    SEL_LEDG,
    SEL_KEY,
    SEL_KEYSTAT,
    SEL_SWITCH
  } io_sel_e;

  // Word-aligned register select; the byte offset is not part of the match.
  function automatic io_sel_e decode_sel(input logic [WORD_SIZE-1:2] word_addr);
    io_sel_e sel;
    case ({word_addr, 2'b00})
      ADDR_HEX:     sel = SEL_HEX;
      ADDR_LEDR:    sel = SEL_LEDR;
      ADDR_LEDG:    sel = SEL_LEDG;
      ADDR_KEY:     sel = SEL_KEY;
      ADDR_KEYSTAT: sel = SEL_KEYSTAT;
      ADDR_SWITCH:  sel = SEL_SWITCH;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/niu32_debounce.sv
// Two-flop synchronizer plus per-bit stability counter for board inputs.
// RESET_VAL is the idle level of the raw input; the outputs are normalised
// so that 1 always means "moved away from idle" (e.g. an active-low key
// idles at 1 and reads 1 when pressed).
module niu32_debounce
  import niu32_pkg::*;
#(
  parameter int                 WIDTH           = 4,
  parameter int unsigned        DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0]   RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] norm;
  logic [WIDTH-1:0] settle;

  // Bring the asynchronous inputs into the clk domain.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking = here would collapse the two synchronizer stages into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign norm = sync2 ^ RESET_VAL;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;

    // Fires on the cycle the new value has been stable long enough.
    assign settle[i] = (norm[i] != level[i]) && (cnt == CNT_LAST);

    // Count consecutive cycles the synchronised value differs from the output.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (norm[i] == level[i] || settle[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Flip each output bit when its counter says the new value has settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else begin
      level <= level ^ settle;
    end
  end

  // Rising on the coming edge, so a consumer can register it on the same
  // edge that updates level.
  assign rise = settle & norm;

endmodule

// File: rtl/niu32_mmio_responder.sv
// Target for Niu32 loads and stores to the 0xFFFF_xxxx I/O page: output
// registers for HEX/LEDR/LEDG, debounced KEY/SWITCH inputs, sticky key
// flags, and registered read data with a one-cycle rvalid pulse.
module niu32_mmio_responder
  import niu32_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 we,
  input  logic                 re,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 rvalid,
  output logic                 hit,
  output logic [15:0]          hex_val,
  output logic [9:0]           ledr,
  output logic [7:0]           ledg,
  input  logic [3:0]           key_n,
  input  logic [9:0]           switch_in
);

  io_sel_e              sel;
  logic                 rd_hit;
  logic [3:0]           key_level;
  logic [3:0]           key_rise;
  logic [3:0]           keystat;
  logic [3:0]           keystat_clr;
  logic [9:0]           sw_level;
  logic [9:0]           sw_rise;
  logic [WORD_SIZE-1:0] rd_mux;
  logic                 unused_bits;

  assign hit    = (addr[31:16] == IO_PAGE);
  assign sel    = decode_sel(addr[WORD_SIZE-1:2]);
  assign rd_hit = re && hit;

  // Byte offset, upper store bits and switch edges have no consumer.
  assign unused_bits = ^{addr[1:0], wdata[31:16], sw_rise};

  niu32_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (4'hF)
  ) u_key_db (
    .clk   (clk),
    .reset (reset),
    .raw   (key_n),
    .level (key_level),
    .rise  (key_rise)
  );

  niu32_debounce #(
    .WIDTH           (10),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (10'h000)
  ) u_sw_db (
    .clk   (clk),
    .reset (reset),
    .raw   (switch_in),
    .level (sw_level),
    .rise  (sw_rise)
  );

  // W1C mask for the sticky flags; only a store to KEYSTAT clears anything.
  assign keystat_clr = (we && sel == SEL_KEYSTAT) ? wdata[3:0] : 4'h0;

  // Read mux over current register values, so a same-cycle store is not seen.
  // NOTE: default assignment first keeps every path driven and avoids a latch.
  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_HEX:     rd_mux = WORD_SIZE'(hex_val);
      SEL_LEDR:    rd_mux = WORD_SIZE'(ledr);
      SEL_LEDG:    rd_mux = WORD_SIZE'(ledg);
      SEL_KEY:     rd_mux = WORD_SIZE'(key_level);
      SEL_KEYSTAT: rd_mux = WORD_SIZE'(keystat);
      SEL_SWITCH:  rd_mux = WORD_SIZE'(sw_level);
      default:     rd_mux = '0;
    endcase
  end

  // Writable output registers; sel is only non-NONE inside the I/O page.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_val <= '0;
      ledr    <= '0;
      ledg    <= '0;
    end else if (we) begin
      case (sel)
        SEL_HEX:  hex_val <= wdata[15:0];
        SEL_LEDR: ledr    <= wdata[9:0];
        SEL_LEDG: ledg    <= wdata[7:0];
        default:  ;
      endcase
    end
  end

  // Sticky key-press flags; a new press outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keystat <= '0;
    end else begin
      keystat <= (keystat & ~keystat_clr) | key_rise;
    end
  end

  // Registered read response: rvalid pulses per accepted load, rdata holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_hit;
      if (rd_hit) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule
